pre_switch: RTL

//  Receive-direction companion of the transmit-side switch injector: merges two redundant

---
 rtl/pre_switch_pkg.sv | 22 ++
 rtl/pre_switch_gap_timer.sv | 28 ++
 rtl/pre_switch.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pre_switch_pkg.sv
// Shared types and widths for the redundant-RX merger (pre_switch) and its gap timer.
package pre_switch_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_FOLLOW = 2'd1,
        ST_IFG    = 2'd2
    } state_e;

    // One GMII receive beat
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              dv;
        logic              er;
    } gmii_t;

    localparam gmii_t GMII_IDLE = '0;

endpackage

// File: rtl/pre_switch_gap_timer.sv
// Inter-frame gap counter: load clears, en counts, done_c flags the last gap cycle.
module pre_switch_gap_timer
    import pre_switch_pkg::*;
#(
    parameter int unsigned IFG_CLOCKS = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_done_c
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_done_c = (r_cnt == CNT_W'(IFG_CLOCKS - 1));

endmodule

// File: rtl/pre_switch.sv
// Merges two redundant GMII RX streams, switching ports only between frames with a forced gap.
// Optional PRE_SWITCH_STATS_EN adds switch_count / drop_count statistics outputs.
module pre_switch
    import pre_switch_pkg::*;
#(
    parameter int unsigned IFG_CLOCKS = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              select,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_dv,
    input  logic              a_er,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_dv,
    input  logic              b_er,
    output logic [DATA_W-1:0] up_data,
    output logic              up_dv,
    output logic              up_er,
    output logic              active,
    output logic              switch_done
`ifdef PRE_SWITCH_STATS_EN
    ,
    output logic [CNT_W-1:0]  switch_count,
    output logic [CNT_W-1:0]  drop_count
`endif
);

    state_e r_state, w_state_nxt;
    logic   r_cur, w_cur_nxt;
    logic   r_changed, w_changed_nxt;
    logic   r_done, w_done_nxt;
    gmii_t  r_up, w_up_nxt;
    logic   w_port;
    gmii_t  w_in;
    logic   w_gap_load, w_gap_en, w_gap_done;

    // In SYNC the requested port is already looked at, so a pending switch costs no extra cycle
    assign w_port = (r_state == ST_SYNC) ? select : r_cur;
    assign w_in   = w_port ? gmii_t'{data: b_data, dv: b_dv, er: b_er}
                           : gmii_t'{data: a_data, dv: a_dv, er: a_er};

    pre_switch_gap_timer #(
        .IFG_CLOCKS (IFG_CLOCKS)
    ) u_gap_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_gap_load),
        .i_en     (w_gap_en),
        .o_done_c (w_gap_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_SYNC;
            r_cur     <= 1'b0;
            r_changed <= 1'b0;
            r_done    <= 1'b0;
            r_up      <= GMII_IDLE;
        end else begin
            r_state   <= w_state_nxt;
            r_cur     <= w_cur_nxt;
            r_changed <= w_changed_nxt;
            r_done    <= w_done_nxt;
            r_up      <= w_up_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cur_nxt     = r_cur;
        w_changed_nxt = r_changed;
        w_done_nxt    = 1'b0;
        w_up_nxt      = GMII_IDLE;
        w_gap_load    = 1'b0;
        w_gap_en      = 1'b0;
        case (r_state)
            ST_SYNC: begin
                if (select != r_cur) begin
                    w_cur_nxt     = select;
                    w_changed_nxt = 1'b1;
                end
                // A frame already in flight is swallowed until its dv falls
                if (!w_in.dv) begin
                    w_state_nxt   = ST_FOLLOW;
                    w_done_nxt    = w_changed_nxt;
                    w_changed_nxt = 1'b0;
                end
            end
            ST_FOLLOW: begin
                if ((select != r_cur) && !w_in.dv) begin
                    w_cur_nxt     = select;
                    w_changed_nxt = 1'b1;
                    w_gap_load    = 1'b1;
                    w_state_nxt   = ST_IFG;
                end else begin
                    w_up_nxt = w_in;
                end
            end
            ST_IFG: begin
                w_gap_en = 1'b1;
                if (w_gap_done) begin
                    w_state_nxt = ST_SYNC;
                end
            end
            default: begin
                w_state_nxt = ST_SYNC;
            end
        endcase
    end

    assign up_data     = r_up.data;
    assign up_dv       = r_up.dv;
    assign up_er       = r_up.er;
    assign active      = r_cur;
    assign switch_done = r_done;

`ifdef PRE_SWITCH_STATS_EN
    logic [CNT_W-1:0] r_switch_cnt;
    logic [CNT_W-1:0] r_drop_cnt;
    logic             r_drop_armed;
    logic             w_drop_new;

    // A discarded frame counts once; a port change in SYNC exposes a different frame
    assign w_drop_new = (r_state == ST_SYNC) && w_in.dv && (!r_drop_armed || (w_cur_nxt != r_cur));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_switch_cnt <= '0;
            r_drop_cnt   <= '0;
            r_drop_armed <= 1'b0;
        end else begin
            if (w_cur_nxt != r_cur) begin
                r_switch_cnt <= r_switch_cnt + CNT_W'(1);
            end
            if (w_drop_new && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
            r_drop_armed <= (r_state == ST_SYNC) && w_in.dv;
        end
    end

    assign switch_count = r_switch_cnt;
    assign drop_count   = r_drop_cnt;
`endif

endmodule
